// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, FSM state encoding and SPI mode.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // {CPOL, CPHA}; this master implements mode 0 only.
  localparam logic [1:0] SPI_MODE = 2'b00;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDone = 2'd2
  } spi_state_e;

  function automatic logic sck_idle_level(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock divider: toggles sck every CLK_DIV clk cycles while enabled and
// flags the clk cycle on which each rising or falling toggle takes effect.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam logic SckIdle = sck_idle_level(SPI_MODE);

  logic [7:0] r_cnt;
  logic       r_sck;
  logic       w_tick;

  assign w_tick     = i_en && (r_cnt == 8'(CLK_DIV - 1));
  assign o_rise_stb = w_tick && !r_sck;
  assign o_fall_stb = w_tick && r_sck;
  assign o_sck      = r_sck;

  // Disabling the generator parks it, so every transfer starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
      r_sck <= SckIdle;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit full-duplex transfer per accepted start,
// MSB first, with a one-cycle done pulse and registered outputs.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              ss
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);

  spi_state_e        r_state;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic [BitW-1:0]   r_bits;
  logic              r_busy;
  logic              r_done;
  logic              r_mosi;
  logic              r_ss;

  logic w_en;
  logic w_rise;
  logic w_fall;
  logic w_last;

  assign w_en   = (r_state == StXfer);
  // r_bits counts completed falling toggles; the DATA_W-th one ends the word.
  assign w_last = w_fall && (r_bits == BitW'(DATA_W - 1));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .o_sck      (sck),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StXfer;
            r_tx    <= din;
            r_rx    <= '0;
            r_mosi  <= din[DATA_W-1];
            r_ss    <= 1'b0;
            r_busy  <= 1'b1;
            r_bits  <= '0;
          end
        end
        StXfer: begin
          if (w_rise) begin
            r_rx <= {r_rx[DATA_W-2:0], miso};
          end
          if (w_last) begin
            r_state <= StDone;
            r_ss    <= 1'b1;
            r_dout  <= r_rx;
            r_done  <= 1'b1;
          end else if (w_fall) begin
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            r_mosi <= r_tx[DATA_W-2];
            r_bits <= r_bits + BitW'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_ss    <= 1'b1;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;
  assign mosi = r_mosi;
  assign ss   = r_ss;

endmodule
